// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and element-index helper for the
// sequential 3x3 matrix multiplier.
package matmul_pkg;

    localparam int DIM    = 3;
    localparam int NELEM  = DIM * DIM;
    localparam int DATA_W = 8;
    // 3*255*255 = 195075 needs 18 bits, so the accumulator never overflows.
    localparam int ACC_W  = 2 * DATA_W + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2
    } state_t;

    function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
        return 4'(r) * 4'd3 + 4'(c);
    endfunction

endpackage

// File: rtl/matmul3x3_seq_if.sv
// Handshake and matrix buses between the scan loader side and the multiplier.
interface matmul3x3_seq_if;
    import matmul_pkg::*;

    logic                     scan_enable;
    logic                     start;
    logic [NELEM*DATA_W-1:0]  A_in;
    logic [NELEM*DATA_W-1:0]  B_in;
    logic                     busy;
    logic                     done;
    logic                     C_valid;
    logic [NELEM*ACC_W-1:0]   C_out;

    modport master (
        output scan_enable, start, A_in, B_in,
        input  busy, done, C_valid, C_out
    );

    modport slave (
        input  scan_enable, start, A_in, B_in,
        output busy, done, C_valid, C_out
    );

endinterface

// File: rtl/mat_mac.sv
// One unsigned multiply-accumulate step; clr_i starts a fresh dot product.
module mat_mac
    import matmul_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [ACC_W-1:0]  acc_i,
    input  logic              clr_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [2*DATA_W-1:0] prod;

    assign prod  = a_i * b_i;
    assign acc_o = (clr_i ? '0 : acc_i) + ACC_W'(prod);

endmodule

// File: rtl/matmul3x3_seq.sv
// Sequential 3x3 unsigned matrix multiplier: one MAC per cycle, 27 cycles per
// product, result held on C_out with C_valid until the next accepted start.
module matmul3x3_seq
    import matmul_pkg::*;
(
    input logic             Clock,
    input logic             reset,
    matmul3x3_seq_if.slave  bus
);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cvalid_q, cvalid_d;
    logic                load, mac_en, last_mac;

    logic [DATA_W-1:0]   a_q [NELEM];
    logic [DATA_W-1:0]   b_q [NELEM];
    logic [ACC_W-1:0]    c_q [NELEM];
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    mac_acc;
    logic [1:0]          i_q, j_q, k_q;
    logic [3:0]          a_sel, b_sel, c_sel;

    assign a_sel    = idx(i_q, k_q);
    assign b_sel    = idx(k_q, j_q);
    assign c_sel    = idx(i_q, j_q);
    assign last_mac = (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);

    mat_mac u_mac (
        .a_i   (a_q[a_sel]),
        .b_i   (b_q[b_sel]),
        .acc_i (acc_q),
        .clr_i (k_q == 2'd0),
        .acc_o (mac_acc)
    );

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cvalid_q <= cvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cvalid_d = cvalid_q;
        load     = 1'b0;
        mac_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.scan_enable) begin
                    state_d  = COMPUTE;
                    busy_d   = 1'b1;
                    cvalid_d = 1'b0;
                    load     = 1'b1;
                end
            end
            COMPUTE: begin
                mac_en = 1'b1;
                if (last_mac) begin
                    state_d  = FINISH;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cvalid_d = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured once at start so later bus changes cannot leak in.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < NELEM; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
                c_q[e] <= '0;
            end
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
        end else if (load) begin
            for (int e = 0; e < NELEM; e++) begin
                a_q[e] <= bus.A_in[DATA_W*e +: DATA_W];
                b_q[e] <= bus.B_in[DATA_W*e +: DATA_W];
                c_q[e] <= '0;
            end
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
        end else if (mac_en) begin
            acc_q <= mac_acc;
            if (k_q == 2'd2) begin
                c_q[c_sel] <= mac_acc;
                k_q        <= '0;
                if (j_q == 2'd2) begin
                    j_q <= '0;
                    i_q <= (i_q == 2'd2) ? 2'd0 : i_q + 2'd1;
                end else begin
                    j_q <= j_q + 2'd1;
                end
            end else begin
                k_q <= k_q + 2'd1;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.C_valid = cvalid_q;

    for (genvar e = 0; e < NELEM; e++) begin : g_cout
        assign bus.C_out[ACC_W*e +: ACC_W] = c_q[e];
    end

endmodule

// File: tb/tb_matmul3x3_seq.sv
// Scoreboard bench for matmul3x3_seq: stimulus pushes expected products,
// a monitor pops and compares whenever done pulses.
module tb_matmul3x3_seq;
    import matmul_pkg::*;

    typedef logic [NELEM*ACC_W-1:0]  cvec_t;
    typedef logic [NELEM*DATA_W-1:0] mvec_t;
    typedef struct {
        cvec_t c;
        int    cyc;
    } exp_t;

    logic Clock = 1'b0;
    logic reset;
    always #5 Clock = ~Clock;

    matmul3x3_seq_if m_if ();

    matmul3x3_seq dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (m_if)
    );

    exp_t  sb [$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    cvec_t last_exp    = '0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input cvec_t act, input cvec_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain triple-sum definition of the matrix product.
    function automatic cvec_t ref_mul(input mvec_t a, input mvec_t b);
        cvec_t c;
        int    sum;
        c = '0;
        for (int r = 0; r < 3; r++)
            for (int col = 0; col < 3; col++) begin
                sum = 0;
                for (int t = 0; t < 3; t++)
                    sum += int'(a[DATA_W*(3*r+t) +: DATA_W]) * int'(b[DATA_W*(3*t+col) +: DATA_W]);
                c[ACC_W*(3*r+col) +: ACC_W] = ACC_W'(sum);
            end
        return c;
    endfunction

    function automatic mvec_t rand_mat();
        mvec_t m;
        for (int e = 0; e < NELEM; e++) m[DATA_W*e +: DATA_W] = DATA_W'($urandom_range(0, 255));
        return m;
    endfunction

    always @(negedge Clock) begin : monitor
        exp_t e;
        if (!reset && m_if.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("C_out", m_if.C_out, e.c);
                chk("done_cycle", cvec_t'(cyc), cvec_t'(e.cyc));
                chk("C_valid_at_done", m_if.C_valid, 1);
                chk("busy_at_done", m_if.busy, 0);
            end
        end
    end

    // mode: 0 plain, 1 start pulse during busy, 2 operand change, 3 reset mid-run
    task automatic run(input mvec_t a, input mvec_t b, input int mode);
        cvec_t exp;
        bit    seen;
        int    ce;
        @(negedge Clock);
        m_if.A_in  = a;
        m_if.B_in  = b;
        m_if.start = 1'b1;
        @(posedge Clock);
        #1;
        ce         = cyc;
        m_if.start = 1'b0;
        exp        = ref_mul(a, b);
        sb.push_back('{exp, ce + 27});
        chk("busy_after_start", m_if.busy, 1);
        chk("C_valid_cleared", m_if.C_valid, 0);
        seen = 1'b0;
        for (int k = 0; k <= 40 && !seen; k++) begin
            @(negedge Clock);
            if (m_if.done) seen = 1'b1;
            if (mode == 1 && k == 5) m_if.start = 1'b1;
            if (mode == 1 && k == 6) m_if.start = 1'b0;
            if (mode == 2 && k == 3) begin
                m_if.A_in = rand_mat();
                m_if.B_in = rand_mat();
            end
            if (mode == 3 && k == 13) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", m_if.busy, 0);
                chk("rst_done", m_if.done, 0);
                chk("rst_C_valid", m_if.C_valid, 0);
                chk("rst_C_out", m_if.C_out, 0);
                void'(sb.pop_back());
                @(negedge Clock);
                reset = 1'b0;
                return;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge Clock);
        chk("done_pulse_end", m_if.done, 0);
        chk("C_out_hold", m_if.C_out, exp);
        chk("C_valid_hold", m_if.C_valid, 1);
        last_exp = exp;
        if (mode == 1) begin
            repeat (35) @(negedge Clock);
            chk("late_start_ignored", m_if.busy, 0);
            chk("result_unchanged", m_if.C_out, exp);
        end
    endtask

    initial begin
        mvec_t a, b;
        reset            = 1'b1;
        m_if.scan_enable = 1'b0;
        m_if.start       = 1'b0;
        m_if.A_in        = '0;
        m_if.B_in        = '0;
        repeat (2) @(negedge Clock);
        chk("reset_busy", m_if.busy, 0);
        chk("reset_done", m_if.done, 0);
        chk("reset_C_valid", m_if.C_valid, 0);
        chk("reset_C_out", m_if.C_out, 0);
        reset = 1'b0;

        a = '0;
        for (int e = 0; e < NELEM; e++) b[DATA_W*e +: DATA_W] = DATA_W'(e + 1);
        for (int e = 0; e < NELEM; e += 4) a[DATA_W*e +: DATA_W] = 8'd1;
        run(a, b, 0);
        chk("identity_is_B", m_if.C_out, cvec_t'({18'd9, 18'd8, 18'd7, 18'd6, 18'd5, 18'd4, 18'd3, 18'd2, 18'd1}));

        a = '1;
        run(a, a, 0);
        chk("max_values", m_if.C_out, {9{18'h2FA03}});

        run(b, b, 0);
        chk("known_product", m_if.C_out,
            cvec_t'({18'd150, 18'd126, 18'd102, 18'd96, 18'd81, 18'd66, 18'd42, 18'd36, 18'd30}));

        run(rand_mat(), rand_mat(), 1);

        @(negedge Clock);
        m_if.scan_enable = 1'b1;
        m_if.start       = 1'b1;
        repeat (3) @(negedge Clock);
        chk("scan_start_ignored", m_if.busy, 0);
        chk("scan_result_kept", m_if.C_out, last_exp);
        m_if.start       = 1'b0;
        m_if.scan_enable = 1'b0;

        run(rand_mat(), rand_mat(), 2);
        run(rand_mat(), rand_mat(), 3);
        run(rand_mat(), rand_mat(), 0);

        for (int n = 0; n < 12; n++) run(rand_mat(), rand_mat(), 0);

        repeat (3) @(negedge Clock);
        if (sb.size() != 0) chk("scoreboard_drained", cvec_t'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
